// File: rtl/bsg_dlatch_ctrl_pkg.sv
// Shared types and width helper for the latch write controller and its arbiter.
package bsg_dlatch_ctrl_pkg;

    typedef enum logic [1:0] {e_idle, e_setup, e_open, e_hold} state_e;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int lg_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_dlatch_rr_arb.sv
// Combinational round-robin grant: first asserted v_i at or after ptr_i wins.
module bsg_dlatch_rr_arb
    import bsg_dlatch_ctrl_pkg::*;
#(
    parameter int num_req_p = 2,
    localparam int lg_req_lp = lg_f(num_req_p)
) (
    input  logic [num_req_p-1:0] v_i,
    input  logic [lg_req_lp-1:0] ptr_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [lg_req_lp-1:0] id_o
);

    logic                 found;
    logic [lg_req_lp-1:0] idx;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = lg_req_lp'((int'(ptr_i) + i) % num_req_p);
            if (!found && v_i[idx]) begin
                grant_o[idx] = 1'b1;
                id_o         = idx;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_dlatch_write_ctrl.sv
// Shares one latch bank among requesters via a SETUP/OPEN/HOLD write sequence.
// Define BSG_DLATCH_WRITE_CTRL_PARITY_EN to append an even-parity bit to latch_data_o.
module bsg_dlatch_write_ctrl
    import bsg_dlatch_ctrl_pkg::*;
#(
    parameter int width_p       = 32,
    parameter int els_p         = 8,
    parameter int num_req_p     = 2,
    parameter int open_cycles_p = 1,
    localparam int lg_els_lp = lg_f(els_p),
    localparam int lg_req_lp = lg_f(num_req_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           v_i,
    input  logic [num_req_p*lg_els_lp-1:0] addr_i,
    input  logic [num_req_p*width_p-1:0]   data_i,
    output logic [num_req_p-1:0]           ready_o,
    output logic [els_p-1:0]               latch_en_o,
`ifdef BSG_DLATCH_WRITE_CTRL_PARITY_EN
    output logic [width_p:0]               latch_data_o,
`else
    output logic [width_p-1:0]             latch_data_o,
`endif
    output logic                           busy_o,
    output logic                           done_v_o,
    output logic [lg_req_lp-1:0]           done_id_o,
    output logic                           err_v_o
);

`ifdef BSG_DLATCH_WRITE_CTRL_PARITY_EN
    localparam int data_w_lp = width_p + 1;
`else
    localparam int data_w_lp = width_p;
`endif
    localparam int cnt_w_lp = lg_f(open_cycles_p);

    state_e                 state_q;
    logic [lg_req_lp-1:0]   ptr_q, ptr_d, id_q, gnt_id;
    logic [num_req_p-1:0]   gnt;
    logic [lg_els_lp-1:0]   addr_q;
    logic [data_w_lp-1:0]   data_q, data_d;
    logic [els_p-1:0]       en_q, en_d;
    logic                   err_q, oor;
    logic [cnt_w_lp-1:0]    cnt_q;

    logic [lg_els_lp-1:0]   addr_arr [num_req_p];
    logic [width_p-1:0]     data_arr [num_req_p];

    for (genvar r = 0; r < num_req_p; r++) begin : g_unpack
        assign addr_arr[r] = addr_i[r*lg_els_lp +: lg_els_lp];
        assign data_arr[r] = data_i[r*width_p +: width_p];
    end

    bsg_dlatch_rr_arb #(.num_req_p(num_req_p)) arb (
        .v_i     (v_i),
        .ptr_i   (ptr_q),
        .grant_o (gnt),
        .id_o    (gnt_id)
    );

    always_comb begin
        ptr_d = (gnt_id == lg_req_lp'(num_req_p - 1)) ? '0 : gnt_id + 1'b1;
`ifdef BSG_DLATCH_WRITE_CTRL_PARITY_EN
        data_d = {^data_arr[gnt_id], data_arr[gnt_id]};
`else
        data_d = data_arr[gnt_id];
`endif
        // An out-of-range address must never open any latch.
        oor  = {1'b0, addr_q} >= (lg_els_lp + 1)'(els_p);
        en_d = oor ? '0 : (els_p'(1) << addr_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            ptr_q   <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                e_idle: if (|gnt) begin
                    addr_q  <= addr_arr[gnt_id];
                    data_q  <= data_d;
                    id_q    <= gnt_id;
                    ptr_q   <= ptr_d;
                    state_q <= e_setup;
                end
                e_setup: begin
                    en_q    <= en_d;
                    err_q   <= oor;
                    cnt_q   <= cnt_w_lp'(open_cycles_p - 1);
                    state_q <= e_open;
                end
                e_open: begin
                    err_q <= 1'b0;
                    if (cnt_q == '0) begin
                        en_q    <= '0;
                        state_q <= e_hold;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                e_hold:  state_q <= e_idle;
                default: state_q <= e_idle;
            endcase
        end
    end

    assign ready_o      = (state_q == e_idle) ? gnt : '0;
    assign latch_en_o   = en_q;
    assign latch_data_o = data_q;
    assign busy_o       = (state_q != e_idle);
    assign done_v_o     = (state_q == e_hold);
    assign done_id_o    = (state_q == e_hold) ? id_q : '0;
    assign err_v_o      = err_q;

endmodule

// File: tb/tb_bsg_dlatch_write_ctrl.sv
// Directed vector table plus corner sequences and a random stability phase.
module tb_bsg_dlatch_write_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 8 words, open 1 cycle.  DUT B: 6 words, open 3 cycles.
    logic        rst_a, rst_b;
    logic [1:0]  v_a, v_b, rdy_a, rdy_b;
    logic [5:0]  addr_a, addr_b;
    logic [63:0] data_a, data_b;
    logic [7:0]  en_a;
    logic [5:0]  en_b;
`ifdef BSG_DLATCH_WRITE_CTRL_PARITY_EN
    logic [32:0] ld_a, ld_b;
`else
    logic [31:0] ld_a, ld_b;
`endif
    logic busy_a, done_a, id_a, err_a;
    logic busy_b, done_b, id_b, err_b;

    bsg_dlatch_write_ctrl #(.width_p(32), .els_p(8), .num_req_p(2), .open_cycles_p(1)) dut_a (
        .clk_i(clk), .reset_i(rst_a), .v_i(v_a), .addr_i(addr_a), .data_i(data_a),
        .ready_o(rdy_a), .latch_en_o(en_a), .latch_data_o(ld_a), .busy_o(busy_a),
        .done_v_o(done_a), .done_id_o(id_a), .err_v_o(err_a));

    bsg_dlatch_write_ctrl #(.width_p(32), .els_p(6), .num_req_p(2), .open_cycles_p(3)) dut_b (
        .clk_i(clk), .reset_i(rst_b), .v_i(v_b), .addr_i(addr_b), .data_i(data_b),
        .ready_o(rdy_b), .latch_en_o(en_b), .latch_data_o(ld_b), .busy_o(busy_b),
        .done_v_o(done_b), .done_id_o(id_b), .err_v_o(err_b));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [2:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  rdy;
        logic [7:0]  en;
        logic [31:0] dat;
        logic        busy, done, id, err;
    } vec_t;

    vec_t tv [18];

    // Latch data must not move while an enable is high or in the adjacent cycles.
    logic        mon_on = 1'b0;
    logic [31:0] prev_ld = '0;
    logic [7:0]  prev_en = '0;
    always @(negedge clk) begin
        if (mon_on) begin
            chk("en_onehot0", 64'($onehot0(en_a)), 64'(1'b1));
            if (|en_a || |prev_en) chk("data_stable", 64'(ld_a[31:0]), 64'(prev_ld));
        end
        prev_ld = ld_a[31:0];
        prev_en = en_a;
    end

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            v_a    = tv[i].v;
            addr_a = {tv[i].a1, tv[i].a0};
            data_a = {tv[i].d1, tv[i].d0};
            @(negedge clk);
            chk($sformatf("row%0d ready", i), 64'(rdy_a), 64'(tv[i].rdy));
            chk($sformatf("row%0d en", i), 64'(en_a), 64'(tv[i].en));
            chk($sformatf("row%0d data", i), 64'(ld_a[31:0]), 64'(tv[i].dat));
            chk($sformatf("row%0d busy", i), 64'(busy_a), 64'(tv[i].busy));
            chk($sformatf("row%0d done", i), 64'(done_a), 64'(tv[i].done));
            chk($sformatf("row%0d done_id", i), 64'(id_a), 64'(tv[i].id));
            chk($sformatf("row%0d err", i), 64'(err_a), 64'(tv[i].err));
            @(posedge clk); #1;
        end
    endtask

    logic [1:0]  hs;
    logic        gidx;
    logic [2:0]  exp_addr;
    logic [31:0] exp_data;
    int          n_grant, n_done, n_err;

    initial begin
        //            v      a0    a1    d0            d1            rdy    en     dat           b     d     id    e
        tv[0]  = '{2'b01, 3'd3, 3'd0, 32'hDEADBEEF, 32'h0,        2'b01, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{2'b00, 3'd0, 3'd0, 32'h0,        32'h0,        2'b00, 8'h00, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{2'b00, 3'd0, 3'd0, 32'h0,        32'h0,        2'b00, 8'h08, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{2'b00, 3'd0, 3'd0, 32'h0,        32'h0,        2'b00, 8'h00, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[4]  = '{2'b00, 3'd0, 3'd0, 32'h0,        32'h0,        2'b00, 8'h00, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{2'b11, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b01, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{2'b11, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b00, 8'h00, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{2'b11, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b00, 8'h02, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{2'b11, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b00, 8'h00, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{2'b11, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b10, 8'h00, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[10] = '{2'b11, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b00, 8'h00, 32'h22222222, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[11] = '{2'b11, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b00, 8'h04, 32'h22222222, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[12] = '{2'b11, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b00, 8'h00, 32'h22222222, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[13] = '{2'b11, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b01, 8'h00, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[14] = '{2'b00, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b00, 8'h00, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[15] = '{2'b00, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b00, 8'h02, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[16] = '{2'b00, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b00, 8'h00, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[17] = '{2'b00, 3'd1, 3'd2, 32'h11111111, 32'h22222222, 2'b00, 8'h00, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1;
        v_a = '0; v_b = '0; addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
        n_grant = 0; n_done = 0; n_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst en_a", 64'(en_a), 64'(0));
        chk("rst data_a", 64'(ld_a), 64'(0));
        chk("rst busy_a", 64'(busy_a), 64'(0));
        chk("rst done_a", 64'(done_a), 64'(0));
        chk("rst err_a", 64'(err_a), 64'(0));
        chk("rst busy_b", 64'(busy_b), 64'(0));
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        mon_on = 1'b1;

        // single write, then contention from a freshly reset pointer
        run_rows(0, 4);
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        run_rows(5, 17);

`ifdef BSG_DLATCH_WRITE_CTRL_PARITY_EN
        v_a = 2'b01; addr_a = 6'd0; data_a = 64'h7;
        @(posedge clk); #1;
        v_a = '0;
        @(negedge clk);
        chk("parity 0x7", 64'(ld_a[32]), 64'(1));
        repeat (3) @(posedge clk); #1;
        v_a = 2'b01; data_a = 64'h3;
        @(posedge clk); #1;
        v_a = '0;
        @(negedge clk);
        chk("parity 0x3", 64'(ld_a[32]), 64'(0));
        repeat (3) @(posedge clk); #1;
`endif

        // out-of-range address on B (els_p=6): no enable, one err pulse, done still fires
        v_b = 2'b01; addr_b = {3'd0, 3'd7}; data_b = 64'h5;
        @(negedge clk);
        chk("oor ready", 64'(rdy_b), 64'(2'b01));
        @(posedge clk); #1;
        v_b = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("oor c%0d en", k), 64'(en_b), 64'(0));
            chk($sformatf("oor c%0d err", k), 64'(err_b), 64'(k == 1));
            chk($sformatf("oor c%0d done", k), 64'(done_b), 64'(k == 4));
            if (err_b) n_err++;
            @(posedge clk); #1;
        end
        chk("oor err count", 64'(n_err), 64'(1));
        chk("oor back idle", 64'(busy_b), 64'(0));

        // reset during the second OPEN cycle of B (pointer is 1 at this point)
        v_b = 2'b01; addr_b = {3'd0, 3'd4}; data_b = 64'h77;
        @(negedge clk);
        chk("rsto ready", 64'(rdy_b), 64'(2'b01));
        @(posedge clk); #1;
        v_b = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsto open1 en", 64'(en_b), 64'(6'h10));
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(negedge clk);
        chk("rsto open2 en", 64'(en_b), 64'(6'h10));
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(negedge clk);
        chk("rsto en", 64'(en_b), 64'(0));
        chk("rsto busy", 64'(busy_b), 64'(0));
        chk("rsto data", 64'(ld_b), 64'(0));
        chk("rsto err", 64'(err_b), 64'(0));
        chk("rsto id", 64'(id_b), 64'(0));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rsto no done %0d", k), 64'(done_b), 64'(0));
            @(negedge clk);
        end
        v_b = 2'b11; addr_b = {3'd1, 3'd2};
        #1;
        chk("rsto ptr zero", 64'(rdy_b), 64'(2'b01));
        v_b = '0;

        // random requesters on A; payload held until granted
        @(posedge clk); #1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            chk("rand grant onehot", 64'($onehot0(rdy_a)), 64'(1'b1));
            if (|en_a) begin
                chk("rand en", 64'(en_a), 64'(8'h01 << exp_addr));
                chk("rand data", 64'(ld_a[31:0]), 64'(exp_data));
            end
            if (done_a) n_done++;
            hs = v_a & rdy_a;
            if (|hs) begin
                gidx     = hs[1];
                exp_addr = addr_a[gidx*3 +: 3];
                exp_data = data_a[gidx*32 +: 32];
                n_grant++;
            end
            @(posedge clk); #1;
            v_a = v_a & ~hs;
            for (int r = 0; r < 2; r++) begin
                if (!v_a[r] && ($urandom_range(0, 1) == 1)) begin
                    v_a[r] = 1'b1;
                    addr_a[r*3 +: 3] = 3'($urandom_range(0, 7));
                    data_a[r*32 +: 32] = $urandom;
                end
            end
        end
        v_a = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (|en_a) begin
                chk("drain en", 64'(en_a), 64'(8'h01 << exp_addr));
                chk("drain data", 64'(ld_a[31:0]), 64'(exp_data));
            end
            if (done_a) n_done++;
        end
        chk("rand done count", 64'(n_done), 64'(n_grant));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
